// File: rtl/mem_cache_responder_if.sv
// CPU-side 16-bit request bus and 128-bit physical-memory line bus.
// master is the environment (CPU plus memory); slave is the cache.
interface mem_cache_responder_if;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport master (
    output mem_address,
    output mem_read,
    output mem_write,
    output mem_byte_enable,
    output mem_wdata,
    input  mem_rdata,
    input  mem_resp,
    input  pmem_address,
    input  pmem_read,
    input  pmem_write,
    input  pmem_wdata,
    output pmem_rdata,
    output pmem_resp
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    input  mem_write,
    input  mem_byte_enable,
    input  mem_wdata,
    output mem_rdata,
    output mem_resp,
    output pmem_address,
    output pmem_read,
    output pmem_write,
    output pmem_wdata,
    input  pmem_rdata,
    input  pmem_resp
  );
endinterface

// File: rtl/mem_cache_responder.sv
// Direct-mapped write-back/write-allocate cache for the 16-bit memory port.
// Define CACHE_PERF_CNT_EN to add saturating hit_count/miss_count outputs.
module mem_cache_responder #(
  parameter int INDEX_BITS = 3
) (
  input  logic clk,
  input  logic reset,
  mem_cache_responder_if.slave bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int SETS = 1 << INDEX_BITS;
  localparam int TW   = 12 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t state;
  state_t state_n;

  logic [SETS-1:0] valid;
  logic [SETS-1:0] dirty;
  logic [TW-1:0]   tags  [SETS];
  logic [127:0]    lines [SETS];

  logic [TW-1:0]         req_tag;
  logic [INDEX_BITS-1:0] idx;
  logic [2:0]            word;
  logic [6:0]            off;
  logic [6:0]            off_hi;
  logic [127:0]          cur_line;
  logic [15:0]           cur_word;
  logic                  hit;
  logic                  req;

  logic fill_en;
  logic wb_done;
  logic wr_hit;
  logic hit_ev;
  logic miss_ev;
  logic unused_addr_lsb;

  assign req_tag  = bus.mem_address[15:4+INDEX_BITS];
  assign idx      = bus.mem_address[3+INDEX_BITS:4];
  assign word     = bus.mem_address[3:1];
  assign off      = {word, 4'b0000};
  assign off_hi   = off | 7'd8;
  assign cur_line = lines[idx];
  assign cur_word = cur_line[off +: 16];
  assign hit      = valid[idx] && (tags[idx] == req_tag);
  assign req      = bus.mem_read || bus.mem_write;

  assign unused_addr_lsb = bus.mem_address[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Read and write both high resolves to a write.
  always_comb begin
    state_n           = state;
    bus.mem_resp      = 1'b0;
    bus.mem_rdata     = '0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.pmem_address  = '0;
    bus.pmem_wdata    = '0;
    fill_en           = 1'b0;
    wb_done           = 1'b0;
    wr_hit            = 1'b0;
    hit_ev            = 1'b0;
    miss_ev           = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) state_n = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          bus.mem_resp = 1'b1;
          hit_ev       = 1'b1;
          if (bus.mem_write) wr_hit = 1'b1;
          else bus.mem_rdata = cur_word;
          state_n = IDLE;
        end else begin
          miss_ev = 1'b1;
          if (valid[idx] && dirty[idx]) state_n = WRITEBACK;
          else state_n = ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {tags[idx], idx, 4'b0000};
        bus.pmem_wdata   = cur_line;
        if (bus.pmem_resp) begin
          wb_done = 1'b1;
          state_n = ALLOCATE;
        end
      end
      ALLOCATE: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {req_tag, idx, 4'b0000};
        if (bus.pmem_resp) begin
          fill_en = 1'b1;
          state_n = COMPARE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (fill_en) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
      if (wb_done) dirty[idx] <= 1'b0;
      if (wr_hit && (bus.mem_byte_enable != 2'b00)) dirty[idx] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      lines[idx] <= bus.pmem_rdata;
      tags[idx]  <= req_tag;
    end else if (wr_hit) begin
      if (bus.mem_byte_enable[0]) lines[idx][off +: 8] <= bus.mem_wdata[7:0];
      if (bus.mem_byte_enable[1]) lines[idx][off_hi +: 8] <= bus.mem_wdata[15:8];
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic filled;

  // A hit that follows this request's own fill is not a true hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      filled     <= 1'b0;
    end else begin
      if (fill_en) filled <= 1'b1;
      else if (hit_ev) filled <= 1'b0;
      if (hit_ev && !filled && (hit_count != 16'hFFFF))
        hit_count <= hit_count + 16'd1;
      if (miss_ev && (miss_count != 16'hFFFF))
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_cache_responder.sv
// Randomized bench for mem_cache_responder against a set-level cache model.
// The memory model uses random latency and stray pmem_resp pulses.
module tb_mem_cache_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;

  mem_cache_responder_if bus ();

`ifdef CACHE_PERF_CNT_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  mem_cache_responder #(.INDEX_BITS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Physical memory: sparse line store with address-derived defaults.
  logic [127:0] pmem [logic [15:0]];

  function automatic logic [127:0] pline(input logic [15:0] a);
    logic [127:0] v;
    if (pmem.exists(a)) return pmem[a];
    for (int w = 0; w < 8; w++)
      v[w*16 +: 16] = a ^ 16'(w * 16'h3131) ^ 16'h5A0F;
    return v;
  endfunction

  int n_rd = 0;
  int n_wr = 0;
  int pm_cyc = 0;
  bit hold_pmem = 0;
  bit both_seen = 0;
  logic [15:0]  wb_addr = '0;
  logic [15:0]  fill_addr = '0;
  logic [127:0] wb_data = '0;

  initial begin
    int cnt;
    int lat;
    cnt = 0;
    lat = $urandom_range(0, 4);
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      if (bus.pmem_read && bus.pmem_write) both_seen = 1;
      if (reset || hold_pmem) begin
        cnt = 0;
      end else if (!(bus.pmem_read || bus.pmem_write)) begin
        cnt = 0;
        if ($urandom_range(0, 7) == 0) begin
          bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
          bus.pmem_resp  = 1'b1;
        end
      end else if (cnt == lat) begin
        if (bus.pmem_write) begin
          pmem[bus.pmem_address] = bus.pmem_wdata;
          wb_addr = bus.pmem_address;
          wb_data = bus.pmem_wdata;
          n_wr++;
        end else begin
          bus.pmem_rdata = pline(bus.pmem_address);
          fill_addr = bus.pmem_address;
          n_rd++;
        end
        bus.pmem_resp = 1'b1;
        pm_cyc += lat + 1;
        cnt = 0;
        lat = $urandom_range(0, 4);
      end else begin
        cnt++;
      end
    end
  end

  // Reference cache state, one entry per set.
  bit           mv [8];
  bit           md [8];
  logic [8:0]   mt [8];
  logic [127:0] ml [8];

  task automatic do_req(input logic wr, input logic [15:0] a,
                        input logic [1:0] be, input logic [15:0] wd,
                        output logic [15:0] got, output int lat,
                        output int nwb);
    logic [2:0]   ix = a[6:4];
    logic [8:0]   tg = a[15:7];
    logic [2:0]   w = a[3:1];
    bit           hit = mv[ix] && (mt[ix] == tg);
    bit           ewb = !hit && mv[ix] && md[ix];
    logic [15:0]  ewa = {mt[ix], ix, 4'h0};
    logic [127:0] ewd = ml[ix];
    logic [15:0]  exp;
    int rd0 = n_rd;
    int wr0 = n_wr;
    int pc0 = pm_cyc;
    int k = 0;
    if (!hit) begin
      ml[ix] = pline({a[15:4], 4'h0});
      mt[ix] = tg;
      mv[ix] = 1;
      md[ix] = 0;
    end
    exp = ml[ix][w*16 +: 16];
    if (wr) begin
      if (be[0]) ml[ix][w*16 +: 8] = wd[7:0];
      if (be[1]) ml[ix][w*16+8 +: 8] = wd[15:8];
      if (be != 2'b00) md[ix] = 1;
    end
    bus.mem_address     = a;
    bus.mem_write       = wr;
    bus.mem_read        = !wr || ($urandom_range(0, 3) == 0);
    bus.mem_byte_enable = be;
    bus.mem_wdata       = wd;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.mem_resp && k < 400);
    got = bus.mem_rdata;
    lat = k + 1;
    nwb = n_wr - wr0;
    check("resp", bus.mem_resp, 1'b1);
    if (!wr) check("rdata", got, exp);
    check("latency", lat, hit ? 2 : 2 + (pm_cyc - pc0) + 1);
    check("fills", n_rd - rd0, hit ? 0 : 1);
    check("wbacks", nwb, ewb ? 1 : 0);
    if (ewb) begin
      check("wb_addr", wb_addr, ewa);
      check("wb_data", wb_data, ewd);
    end
    if (!hit) check("fill_addr", fill_addr, {a[15:4], 4'h0});
    @(negedge clk);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0]  got;
    logic [127:0] l10;
    int lat;
    int nwb;
    int k;
    bus.mem_address     = '0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = '0;
    bus.mem_wdata       = '0;
    for (int i = 0; i < 8; i++) begin
      mv[i] = 0;
      md[i] = 0;
    end
    l10 = pline(16'h0010);
    l10[15:0]  = 16'hBEEF;
    l10[31:16] = 16'hBEEF;
    pmem[16'h0010] = l10;

    repeat (3) @(negedge clk);
    check("rst_resp", bus.mem_resp, 1'b0);
    check("rst_rdata", bus.mem_rdata, 16'h0);
    check("rst_pread", bus.pmem_read, 1'b0);
    check("rst_pwrite", bus.pmem_write, 1'b0);
    check("rst_paddr", bus.pmem_address, 16'h0);
    check("rst_pwdata", bus.pmem_wdata, 128'h0);
    reset = 1'b0;
    @(negedge clk);

    do_req(1'b0, 16'h0010, 2'b00, 16'h0, got, lat, nwb);
    check("cold_rd", got, 16'hBEEF);
    check("cold_fill", fill_addr, 16'h0010);
    do_req(1'b0, 16'h0012, 2'b00, 16'h0, got, lat, nwb);
    check("hit_rd", got, 16'hBEEF);
    check("hit_lat", lat, 2);
    do_req(1'b1, 16'h0012, 2'b01, 16'h1234, got, lat, nwb);
    check("wr_lat", lat, 2);
    do_req(1'b0, 16'h0012, 2'b00, 16'h0, got, lat, nwb);
    check("merge_rd", got, 16'hBE34);
`ifdef CACHE_PERF_CNT_EN
    check("miss_cnt", miss_count, 16'd1);
    check("hit_cnt", hit_count, 16'd3);
`endif

    do_req(1'b0, 16'h0090, 2'b00, 16'h0, got, lat, nwb);
    check("evict_n", nwb, 1);
    check("evict_addr", wb_addr, 16'h0010);
    check("evict_w1", wb_data[31:16], 16'hBE34);
    check("evict_fill", fill_addr, 16'h0090);

    do_req(1'b0, 16'h0150, 2'b00, 16'h0, got, lat, nwb);
    do_req(1'b1, 16'h0150, 2'b00, 16'hFFFF, got, lat, nwb);
    do_req(1'b0, 16'h01D0, 2'b00, 16'h0, got, lat, nwb);
    check("mask0_no_wb", nwb, 0);

    do_req(1'b1, 16'hFFFE, 2'b11, 16'hC0DE, got, lat, nwb);
    do_req(1'b0, 16'hFFFF, 2'b00, 16'h0, got, lat, nwb);
    check("wrap_rd", got, 16'hC0DE);
    do_req(1'b0, 16'h0070, 2'b00, 16'h0, got, lat, nwb);
    check("wrap_wb_addr", wb_addr, 16'hFFF0);

`ifdef CACHE_PERF_CNT_EN
    do_req(1'b0, 16'h0070, 2'b00, 16'h0, got, lat, nwb);
    force dut.hit_count = 16'hFFFF;
    @(negedge clk);
    release dut.hit_count;
    do_req(1'b0, 16'h0070, 2'b00, 16'h0, got, lat, nwb);
    check("hit_sat", hit_count, 16'hFFFF);
`endif

    // Abandon a fill with reset; resident lines must be forgotten.
    do_req(1'b0, 16'h0040, 2'b00, 16'h0, got, lat, nwb);
    hold_pmem = 1;
    bus.mem_address = 16'h0340;
    bus.mem_read    = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.pmem_read && k < 20);
    check("alloc_seen", bus.pmem_read, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_drop", bus.pmem_read, 1'b0);
    check("rst_resp0", bus.mem_resp, 1'b0);
    bus.mem_read = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mv[i] = 0;
      md[i] = 0;
    end
    @(negedge clk);
    reset = 1'b0;
    hold_pmem = 0;
    @(negedge clk);
    k = n_rd;
    do_req(1'b0, 16'h0040, 2'b00, 16'h0, got, lat, nwb);
    check("post_rst_fill", n_rd - k, 1);
`ifdef CACHE_PERF_CNT_EN
    check("rst_miss_cnt", miss_count, 16'd1);
`endif

    for (int i = 0; i < 200; i++) begin
      logic [15:0] a;
      logic        wr;
      a  = {7'h0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
      wr = ($urandom_range(0, 2) == 0);
      do_req(wr, a, 2'($urandom_range(0, 3)), 16'($urandom), got, lat, nwb);
    end

    check("pmem_excl", both_seen, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
